// File: rtl/lc3_mem_pkg.sv
// ============================================================================
// Module   : lc3_mem_pkg
// Brief    : Shared widths, limits and arbiter state encoding for lc3_mem_arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package lc3_mem_pkg;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 16;
  localparam int MAX_REQ    = 8;
  localparam int MAX_RD_LAT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/lc3_mem_arbiter_rr_picker.sv
// ============================================================================
// Module   : rr_picker
// Brief    : Combinational round-robin pick; search starts one past ptr and wraps
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  win_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int   j;
    logic found;
    win_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found    = 1'b1;
        win_o[j] = 1'b1;
        idx_o    = IW'(j);
      end
    end
    any_o = found;
  end

endmodule

`default_nettype wire

// File: rtl/lc3_mem_arbiter.sv
// ============================================================================
// Module   : lc3_mem_arbiter
// Brief    : Round-robin arbiter sharing one single-port synchronous memory.
//            Define MEMARB_LOCK_EN to enable requester lock ownership.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lc3_mem_arbiter
  import lc3_mem_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int RD_LAT  = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              req_we,
  input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]              req_lock,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [DATA_W-1:0]               rdata,
  output logic                            mem_en,
  output logic                            mem_we,
  output logic [ADDR_W-1:0]               mem_addr,
  output logic [DATA_W-1:0]               mem_wdata,
  input  logic [DATA_W-1:0]               mem_rdata
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_RD_LAT);

  arb_state_e          state_q;
  logic [IW-1:0]       idx_q;
  logic [IW-1:0]       ptr_q;
  logic [CW-1:0]       cnt_q;
  logic [NUM_REQ-1:0]  gnt_q;
  logic [NUM_REQ-1:0]  rvalid_q;
  logic [DATA_W-1:0]   rdata_q;
  logic                mem_en_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;

  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  win;
  logic [IW-1:0]       win_idx;
  logic                win_any;

`ifdef MEMARB_LOCK_EN
  logic                owner_vld_q;
  logic [IW-1:0]       owner_q;
  logic                owner_req;

  // A live owner with its request up shuts out everyone else.
  assign owner_req = owner_vld_q && req[owner_q];
  assign elig      = owner_req ? (NUM_REQ'(1) << owner_q) : req;
`else
  logic unused_lock;
  assign unused_lock = ^req_lock;
  assign elig        = req;
`endif

  rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req_i (elig),
    .ptr_i (ptr_q),
    .win_o (win),
    .idx_o (win_idx),
    .any_o (win_any)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      ptr_q       <= IW'(NUM_REQ - 1);
      cnt_q       <= '0;
      gnt_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef MEMARB_LOCK_EN
      owner_vld_q <= 1'b0;
      owner_q     <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
`ifdef MEMARB_LOCK_EN
          if (owner_vld_q && !req[owner_q]) owner_vld_q <= 1'b0;
`endif
          if (win_any) begin
            state_q     <= ISSUE;
            idx_q       <= win_idx;
            gnt_q       <= win;
            mem_en_q    <= 1'b1;
            mem_we_q    <= req_we[win_idx];
            mem_addr_q  <= req_addr[win_idx];
            mem_wdata_q <= req_wdata[win_idx];
`ifdef MEMARB_LOCK_EN
            // Granting with lock low releases ownership.
            owner_vld_q <= req_lock[win_idx];
            owner_q     <= win_idx;
`endif
          end
        end
        ISSUE: begin
          gnt_q       <= '0;
          mem_en_q    <= 1'b0;
          mem_we_q    <= 1'b0;
          mem_addr_q  <= '0;
          mem_wdata_q <= '0;
          ptr_q       <= idx_q;
          cnt_q       <= '0;
          state_q     <= mem_we_q ? IDLE : RD_WAIT;
        end
        RD_WAIT: begin
          if (cnt_q == CW'(RD_LAT - 1)) begin
            rdata_q  <= mem_rdata;
            rvalid_q <= NUM_REQ'(1) << idx_q;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        RESP: begin
          rvalid_q <= '0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rvalid    = rvalid_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

`default_nettype wire
